// File: rtl/axis_sample_source_if.sv
// AXI-Stream beat channel (tvalid/tready/tdata/tlast) shared by the sample source and its sink.
interface axis_sample_source_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_sample_source.sv
// axis_sample_source: FWFT-buffered AXI-Stream transmitter for {magnitude, angle} samples.
// Define AXIS_SAMPLE_SOURCE_DROP_COUNT_EN to add a 16-bit saturating drop_count output.
module axis_sample_source #(
    parameter int C_M00_AXIS_TDATA_WIDTH = 64,
    parameter int FIFO_DEPTH             = 8,
    parameter int FRAME_LEN              = 256
) (
    input  logic                          s00_axis_aclk,
    input  logic                          s00_axis_areset,
    input  logic                          sample_valid,
    input  logic [15:0]                   sample_mag,
    input  logic [15:0]                   sample_angle,
    axis_sample_source_if.master          m00_axis,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
`ifdef AXIS_SAMPLE_SOURCE_DROP_COUNT_EN
    ,
    output logic [15:0]                   drop_count
`endif
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

    logic [C_M00_AXIS_TDATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] packed_sample;
    logic [PTR_W-1:0]                  wr_ptr;
    logic [PTR_W-1:0]                  rd_ptr;
    logic [CNT_W-1:0]                  count;
    logic [BEAT_W-1:0]                 beat_cnt;
    logic                              not_empty;
    logic                              full;
    logic                              pop;
    logic                              push;
    logic                              drop;

    assign packed_sample = C_M00_AXIS_TDATA_WIDTH'({{16{sample_angle[15]}}, sample_angle,
                                                    16'h0000, sample_mag});

    assign not_empty = (count != '0);
    assign full      = (count == DEPTH_C);
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign pop       = not_empty && m00_axis.tready;
    assign push      = sample_valid && (!full || pop);
    assign drop      = sample_valid && full && !pop;

    // Outputs come straight from registers, so tvalid never depends on tready.
    assign m00_axis.tvalid = not_empty;
    assign m00_axis.tdata  = fifo_mem[rd_ptr];
    assign m00_axis.tlast  = not_empty && (beat_cnt == LAST_BEAT);
    assign fifo_count      = count;

    // NOTE: the storage array has no reset; count and pointers alone define which entries are live.
    always_ff @(posedge s00_axis_aclk) begin
        if (push && !s00_axis_areset) begin
            fifo_mem[wr_ptr] <= packed_sample;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beat_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BEAT_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef AXIS_SAMPLE_SOURCE_DROP_COUNT_EN
    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_sample_source.sv
// Self-checking bench for axis_sample_source: queue-based reference model plus directed scenarios.
module tb_axis_sample_source;
    localparam int DEPTH = 8;
    localparam int FLEN  = 4;

    logic        s00_axis_aclk;
    logic        s00_axis_areset;
    logic        sample_valid;
    logic [15:0] sample_mag;
    logic [15:0] sample_angle;
    logic [3:0]  fifo_count;
    logic        overflow;
`ifdef AXIS_SAMPLE_SOURCE_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    axis_sample_source_if #(.DATA_WIDTH(64)) m00_axis ();

    axis_sample_source #(
        .C_M00_AXIS_TDATA_WIDTH(64),
        .FIFO_DEPTH(DEPTH),
        .FRAME_LEN(FLEN)
    ) dut (
        .s00_axis_aclk  (s00_axis_aclk),
        .s00_axis_areset(s00_axis_areset),
        .sample_valid   (sample_valid),
        .sample_mag     (sample_mag),
        .sample_angle   (sample_angle),
        .m00_axis       (m00_axis),
        .fifo_count     (fifo_count),
        .overflow       (overflow)
`ifdef AXIS_SAMPLE_SOURCE_DROP_COUNT_EN
        ,
        .drop_count     (drop_count)
`endif
    );

    initial s00_axis_aclk = 1'b0;
    always #5 s00_axis_aclk = ~s00_axis_aclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the FIFO is a queue, framing is a beat index modulo FLEN.
    logic [63:0] mq[$];
    int          m_beat  = 0;
    bit          m_ovf   = 1'b0;
    int          m_drops = 0;

    function automatic logic [63:0] pack(input logic [15:0] mag, input logic [15:0] ang);
        longint a;
        a = longint'($signed(ang));
        return 64'((a << 32) | longint'(mag));
    endfunction

    function automatic logic [63:0] m_head();
        return (mq.size() != 0) ? mq[0] : 64'hx;
    endfunction

    task automatic model_tick(input bit rst, input bit sv, input logic [63:0] d, input bit rdy);
        if (rst) begin
            mq.delete();
            m_beat  = 0;
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            if (mq.size() != 0 && rdy) begin
                void'(mq.pop_front());
                m_beat = (m_beat + 1) % FLEN;
            end
            if (sv) begin
                if (mq.size() < DEPTH) mq.push_back(d);
                else begin
                    m_ovf = 1'b1;
                    if (m_drops < 65535) m_drops++;
                end
            end
        end
    endtask

    // Drive one cycle at the falling edge, let the rising edge happen, return at the next falling edge.
    task automatic step(input bit rst, input bit sv, input logic [15:0] mag,
                        input logic [15:0] ang, input bit rdy);
        s00_axis_areset = rst;
        sample_valid    = sv;
        sample_mag      = mag;
        sample_angle    = ang;
        m00_axis.tready = rdy;
        @(posedge s00_axis_aclk);
        model_tick(rst, sv, pack(mag, ang), rdy);
        @(negedge s00_axis_aclk);
    endtask

    task automatic test_reset();
        step(1, 1, 16'h5555, 16'h5555, 1);
        step(1, 0, 16'h0, 16'h0, 0);
        n_checks++; if (m00_axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", m00_axis.tvalid); end
        n_checks++; if (m00_axis.tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b want 0", m00_axis.tlast); end
        n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
`ifdef AXIS_SAMPLE_SOURCE_DROP_COUNT_EN
        n_checks++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
`endif
    endtask

    task automatic test_single();
        step(0, 1, 16'h1234, 16'hFF00, 1);
        n_checks++; if (m00_axis.tvalid !== 1'b1) begin n_fail++; $display("FAIL single_tvalid: got %b want 1", m00_axis.tvalid); end
        n_checks++; if (m00_axis.tdata !== 64'hFFFFFF00_00001234) begin n_fail++; $display("FAIL single_tdata: got %h want ffffff0000001234", m00_axis.tdata); end
        n_checks++; if (m00_axis.tlast !== 1'b0) begin n_fail++; $display("FAIL single_tlast: got %b want 0", m00_axis.tlast); end
        step(0, 0, 16'h0, 16'h0, 1);
        n_checks++; if (m00_axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL single_drain_tvalid: got %b want 0", m00_axis.tvalid); end
        n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL single_drain_count: got %0d want 0", fifo_count); end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_v[3];
        logic [15:0] m, a;
        step(1, 0, 16'h0, 16'h0, 0);
        for (int i = 0; i < 3; i++) begin
            m = 16'($urandom); a = 16'($urandom);
            exp_v[i] = pack(m, a);
            step(0, 1, m, a, 0);
        end
        n_checks++; if (fifo_count !== 4'd3) begin n_fail++; $display("FAIL bp_count: got %0d want 3", fifo_count); end
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (m00_axis.tvalid !== 1'b1 || m00_axis.tdata !== exp_v[0]) begin
                n_fail++; $display("FAIL bp_hold cycle %0d: got v=%b d=%h want v=1 d=%h", c, m00_axis.tvalid, m00_axis.tdata, exp_v[0]);
            end
            step(0, 0, 16'h0, 16'h0, 0);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (m00_axis.tvalid !== 1'b1 || m00_axis.tdata !== exp_v[i]) begin
                n_fail++; $display("FAIL bp_drain beat %0d: got v=%b d=%h want v=1 d=%h", i, m00_axis.tvalid, m00_axis.tdata, exp_v[i]);
            end
            step(0, 0, 16'h0, 16'h0, 1);
        end
        n_checks++; if (m00_axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", m00_axis.tvalid); end
    endtask

    task automatic test_overflow();
        logic [63:0] exp_v[10];
        logic [15:0] m, a;
        step(1, 0, 16'h0, 16'h0, 0);
        for (int i = 0; i < 10; i++) begin
            m = 16'($urandom); a = 16'($urandom);
            exp_v[i] = pack(m, a);
            step(0, 1, m, a, 0);
        end
        n_checks++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL ovf_count: got %0d want 8", fifo_count); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
`ifdef AXIS_SAMPLE_SOURCE_DROP_COUNT_EN
        n_checks++; if (drop_count !== 16'd2) begin n_fail++; $display("FAIL ovf_drop_count: got %0d want 2", drop_count); end
`endif
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (m00_axis.tvalid !== 1'b1 || m00_axis.tdata !== exp_v[i]) begin
                n_fail++; $display("FAIL ovf_drain beat %0d: got v=%b d=%h want v=1 d=%h", i, m00_axis.tvalid, m00_axis.tdata, exp_v[i]);
            end
            step(0, 0, 16'h0, 16'h0, 1);
        end
        n_checks++; if (m00_axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b want 0", m00_axis.tvalid); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_full_pop();
        logic [63:0] exp_v[9];
        logic [15:0] m, a;
        step(1, 0, 16'h0, 16'h0, 0);
        for (int i = 0; i < 9; i++) begin
            m = 16'($urandom); a = 16'($urandom);
            exp_v[i] = pack(m, a);
            step(0, 1, m, a, i == 8);
        end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_overflow: got %b want 0", overflow); end
        n_checks++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL fullpop_count: got %0d want 8", fifo_count); end
        for (int i = 1; i < 9; i++) begin
            n_checks++;
            if (m00_axis.tvalid !== 1'b1 || m00_axis.tdata !== exp_v[i]) begin
                n_fail++; $display("FAIL fullpop_drain beat %0d: got v=%b d=%h want v=1 d=%h", i, m00_axis.tvalid, m00_axis.tdata, exp_v[i]);
            end
            step(0, 0, 16'h0, 16'h0, 1);
        end
        n_checks++; if (m00_axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL fullpop_empty: got %b want 0", m00_axis.tvalid); end
    endtask

    // Streams n beats; tlast is expected on every FLEN-th beat counted from the last reset.
    task automatic test_framing(input int n, input bit stalls, input string tag);
        int          k = 0;
        int          pushed = 0;
        int          cyc = 0;
        bit          prev_hold = 1'b0;
        logic [63:0] pd = '0;
        logic        pl = 1'b0;
        bit          sv, rdy;
        while (k < n && cyc < 400) begin
            rdy = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
            sv  = (pushed < n) && (!stalls || (($urandom_range(0, 1) == 1) && mq.size() < DEPTH - 1));
            n_checks++;
            if (m00_axis.tvalid !== (mq.size() != 0)) begin
                n_fail++; $display("FAIL %s_tvalid cycle %0d: got %b want %b", tag, cyc, m00_axis.tvalid, mq.size() != 0);
            end
            if (m00_axis.tvalid === 1'b1) begin
                n_checks++;
                if (m00_axis.tlast !== (((k + 1) % FLEN) == 0)) begin
                    n_fail++; $display("FAIL %s_tlast beat %0d: got %b want %b", tag, k + 1, m00_axis.tlast, ((k + 1) % FLEN) == 0);
                end
                n_checks++;
                if (m00_axis.tdata !== m_head()) begin
                    n_fail++; $display("FAIL %s_tdata beat %0d: got %h want %h", tag, k + 1, m00_axis.tdata, m_head());
                end
            end
            if (prev_hold) begin
                n_checks++;
                if (m00_axis.tvalid !== 1'b1 || m00_axis.tdata !== pd || m00_axis.tlast !== pl) begin
                    n_fail++; $display("FAIL %s_stall_stable cycle %0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                                       tag, cyc, m00_axis.tvalid, m00_axis.tdata, m00_axis.tlast, pd, pl);
                end
            end
            prev_hold = (m00_axis.tvalid === 1'b1) && !rdy;
            pd = m00_axis.tdata;
            pl = m00_axis.tlast;
            if (m00_axis.tvalid === 1'b1 && rdy) k++;
            if (sv) pushed++;
            step(0, sv, 16'($urandom), 16'($urandom), rdy);
            cyc++;
        end
        n_checks++;
        if (k != n) begin n_fail++; $display("FAIL %s_timeout: got %0d beats want %0d", tag, k, n); end
    endtask

    task automatic test_reset_midframe();
        step(1, 0, 16'h0, 16'h0, 0);
        step(0, 1, 16'h1111, 16'h0001, 1);
        step(0, 1, 16'h2222, 16'h0002, 1);
        step(0, 0, 16'h0, 16'h0, 1);
        for (int i = 0; i < 9; i++) step(0, 1, 16'($urandom), 16'($urandom), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 16'h0, 1);
        n_checks++; if (fifo_count !== 4'd5) begin n_fail++; $display("FAIL midrst_pre_count: got %0d want 5", fifo_count); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_overflow: got %b want 1", overflow); end
        step(1, 1, 16'hABCD, 16'h8000, 1);
        n_checks++; if (m00_axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_tvalid: got %b want 0", m00_axis.tvalid); end
        n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", fifo_count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL midrst_overflow: got %b want 0", overflow); end
        n_checks++; if (m00_axis.tlast !== 1'b0) begin n_fail++; $display("FAIL midrst_tlast: got %b want 0", m00_axis.tlast); end
        test_framing(8, 1'b0, "midrst_frame");
    endtask

    task automatic test_random();
        bit sv, rdy;
        step(1, 0, 16'h0, 16'h0, 0);
        for (int c = 0; c < 400; c++) begin
            sv  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 1) == 1);
            n_checks++;
            if (m00_axis.tvalid !== (mq.size() != 0) || fifo_count !== 4'(mq.size()) || overflow !== m_ovf ||
                m00_axis.tlast !== ((mq.size() != 0) && (m_beat == FLEN - 1))) begin
                n_fail++; $display("FAIL rand_ctrl cycle %0d: got v=%b cnt=%0d ovf=%b l=%b want v=%b cnt=%0d ovf=%b l=%b",
                                   c, m00_axis.tvalid, fifo_count, overflow, m00_axis.tlast, mq.size() != 0, mq.size(),
                                   m_ovf, (mq.size() != 0) && (m_beat == FLEN - 1));
            end
            if (mq.size() != 0) begin
                n_checks++;
                if (m00_axis.tdata !== m_head()) begin
                    n_fail++; $display("FAIL rand_tdata cycle %0d: got %h want %h", c, m00_axis.tdata, m_head());
                end
            end
`ifdef AXIS_SAMPLE_SOURCE_DROP_COUNT_EN
            n_checks++;
            if (drop_count !== 16'(m_drops)) begin
                n_fail++; $display("FAIL rand_drop_count cycle %0d: got %0d want %0d", c, drop_count, m_drops);
            end
`endif
            step(0, sv, 16'($urandom), 16'($urandom), rdy);
        end
    endtask

    initial begin
        s00_axis_areset = 1'b1;
        sample_valid    = 1'b0;
        sample_mag      = '0;
        sample_angle    = '0;
        m00_axis.tready = 1'b0;
        @(negedge s00_axis_aclk);
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_full_pop();
        step(1, 0, 16'h0, 16'h0, 0);
        test_framing(10, 1'b0, "frame_cont");
        step(1, 0, 16'h0, 16'h0, 0);
        test_framing(10, 1'b1, "frame_stall");
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule

// File: doc/axis_sample_source.md
Name: axis_sample_source

Overview:
- AXI-Stream transmitter for processed samples; the producing end of the 64-bit stream that passive snoopers tap downstream.
- Accepts one {magnitude, angle} sample per cycle from a local datapath that cannot stall.
- Buffers samples in a small first-word-fall-through FIFO and drives an AXI-Stream master port.
- Obeys downstream backpressure, marks frame boundaries with tlast, and flags dropped samples.

Parameters:
- C_M00_AXIS_TDATA_WIDTH, 64, output data width; fixed at 64; any other value is unsupported.
- FIFO_DEPTH, 8, FIFO entries; power of two, at least 2.
- FRAME_LEN, 256, beats per frame; at least 1; tlast asserts on the last beat of each frame.

Ports:
- s00_axis_aclk  input  1  sole clock; all logic on its rising edge.
- s00_axis_areset  input  1  synchronous, active-high reset.
- sample_valid  input  1  new sample present this cycle; no ready is returned.
- sample_mag  input  16  unsigned magnitude.
- sample_angle  input  16  signed angle.
- m00_axis_tready  input  1  downstream ready.
- m00_axis_tvalid  output  1  beat valid.
- m00_axis_tdata  output  64  packed beat.
- m00_axis_tlast  output  1  last beat of frame.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.
- overflow  output  1  sticky flag: at least one sample was dropped.

Behaviour:
- Clocking/reset: one clock, s00_axis_aclk. s00_axis_areset is synchronous and active-high.
- Reset values (cycle after reset is sampled high): m00_axis_tvalid=0, m00_axis_tlast=0, fifo_count=0, overflow=0; read/write pointers and beat counter = 0. m00_axis_tdata content is don't-care while tvalid=0.
- Inputs are ignored while reset is high.
- Reset mid-frame: FIFO flushed, frame restarts at beat 0; no partial-frame tlast is emitted.
- Packing:
  - tdata[31:0] = {16'h0, sample_mag}.
  - tdata[63:32] = sample_angle sign-extended to 32 bits.
- Push: a push occurs when sample_valid=1 and either (count < FIFO_DEPTH) or a pop occurs in the same cycle.
- Pop: a pop occurs when m00_axis_tvalid && m00_axis_tready.
- fifo_count update: +1 on push only, -1 on pop only, unchanged on push+pop.
- FWFT output:
  - m00_axis_tvalid = (count != 0).
  - m00_axis_tdata = entry at the read pointer.
  - Latency: a sample pushed into an empty FIFO in cycle N shows tvalid=1 with its data in cycle N+1.
  - Pointers wrap modulo FIFO_DEPTH.
- AXI rules:
  - While tvalid=1 and tready=0, tdata and tlast are held stable and tvalid stays high.
  - tvalid never depends combinationally on tready.
  - Full throughput: 1 beat/cycle when tready is held high.
- Drop: sample_valid=1 while count==FIFO_DEPTH with no pop that cycle. The sample is discarded, FIFO contents are unchanged, and overflow is set to 1 from the next cycle until reset.
- Full with simultaneous pop: the sample is accepted (no drop). It is written into the slot being vacated, and count stays FIFO_DEPTH.
- Empty with sample_valid and tready both high: no pop that cycle (tvalid=0); the sample appears next cycle.
- Framing:
  - Beat counter range is 0..FRAME_LEN-1, incremented on each pop, wrapping to 0 after FRAME_LEN-1.
  - m00_axis_tlast = tvalid && (beat counter == FRAME_LEN-1).
  - FRAME_LEN=1 gives tlast on every beat.
  - Dropped samples do not advance the counter.

Optional Feature:
- Macro: AXIS_SAMPLE_SOURCE_DROP_COUNT_EN.
- Defined:
  - Adds output port drop_count, 16 bits: a saturating count of dropped samples.
  - Increments in the cycle after each drop; holds at 16'hFFFF.
  - Reset to 0.
  - overflow still behaves as specified.
- Undefined: the port is absent and only the sticky overflow flag reports drops.

Test Plan:
- Reset, then one sample mag=16'h1234, angle=16'hFF00 with tready=1 -> next cycle tvalid=1, tdata=64'hFFFFFF00_00001234, tlast=0 (FRAME_LEN=256); popped the same cycle, then tvalid=0 and fifo_count=0.
- tready=0, push 3 samples A,B,C -> fifo_count=3; tdata=A held for 10 cycles; raise tready -> A,B,C on 3 consecutive cycles, then tvalid=0.
- tready=0, push 10 samples with FIFO_DEPTH=8 -> fifo_count=8, overflow=1 (drop_count=2 if enabled); drain -> exactly samples 1-8 emerge in order.
- FIFO full, sample_valid=1 and tready=1 in the same cycle -> no drop, overflow stays 0, count stays 8, new sample emerges last.
- FRAME_LEN=4, 10 continuous beats with tready=1 -> tlast on beats 4 and 8 only. Insert random tready stalls -> tlast positions unchanged, tlast stable during stalls.
- Assert reset for 1 cycle mid-frame with FIFO holding 5 entries -> tvalid=0, count=0, overflow=0. The next frame's tlast falls on the FRAME_LEN-th post-reset beat.
